// File: rtl/color_sensor_pkg.sv
// Shared definitions for the colour-recognition path: sensor filter codes,
// sampler FSM states and the class codes produced by the downstream classifier.
package color_sensor_pkg;

   localparam logic [1:0] FILT_RED   = 2'b00;
   localparam logic [1:0] FILT_BLUE  = 2'b01;
   localparam logic [1:0] FILT_CLEAR = 2'b10;
   localparam logic [1:0] FILT_GREEN = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE_R,
      ST_GATE_R,
      ST_SETTLE_G,
      ST_GATE_G,
      ST_SETTLE_B,
      ST_GATE_B,
      ST_DONE
   } sampler_state_t;

   typedef enum logic [2:0] {
      CLASS_WHITE  = 3'd0,
      CLASS_ORANGE = 3'd1,
      CLASS_GREEN  = 3'd2,
      CLASS_RED    = 3'd3,
      CLASS_BLUE   = 3'd4,
      CLASS_YELLOW = 3'd5
   } color_class_t;

   function automatic logic is_gate(sampler_state_t st);
      return st inside {ST_GATE_R, ST_GATE_G, ST_GATE_B};
   endfunction

   function automatic logic is_settle(sampler_state_t st);
      return st inside {ST_SETTLE_R, ST_SETTLE_G, ST_SETTLE_B};
   endfunction

   // Filter that must be selected while the given state is active.
   function automatic logic [1:0] filter_for(sampler_state_t st);
      case (st)
         ST_SETTLE_G, ST_GATE_G: return FILT_GREEN;
         ST_SETTLE_B, ST_GATE_B: return FILT_BLUE;
         default:                return FILT_RED;
      endcase
   endfunction

endpackage

// File: rtl/color_sampler_if.sv
// Bundle between the colour sampler, the light sensor pins and the classifier.
// master is the sampler side; slave is the sensor/classifier environment.
interface color_sampler_if;

   logic       start;
   logic       sensor_out;
   logic       s2;
   logic       s3;
   logic [7:0] red;
   logic [7:0] green;
   logic [7:0] blue;
   logic       valid;
   logic       busy;

   modport master (
      input  start, sensor_out,
      output s2, s3, red, green, blue, valid, busy
   );

   modport slave (
      output start, sensor_out,
      input  s2, s3, red, green, blue, valid, busy
   );

endinterface

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous input followed by a one-cycle
// rising-edge pulse generator.
module sync_edge_detect (
   input  logic clock,
   input  logic reset_n,
   input  logic async_in,
   output logic rise
);

   logic [2:0] sync_q;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[1:0], async_in};
      end
   end

   assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/color_sampler.sv
// Drives the TCS3200 filter selects and counts sensor edges through red,
// green and blue in turn, publishing a saturated 8-bit triple with a valid strobe.
module color_sampler
   import color_sensor_pkg::*;
#(
   parameter int GATE_CYCLES   = 650000,
   parameter int SETTLE_CYCLES = 6500,
   parameter int RAW_W         = 16,
   parameter int SHIFT         = 4
) (
   input  logic      clock,
   input  logic      reset_n,
   color_sampler_if.master bus
);

   localparam int MAX_CYCLES = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   sampler_state_t   state;
   sampler_state_t   next_state;
   logic [CNT_W-1:0] cnt;
   logic [RAW_W-1:0] raw;
   logic [RAW_W-1:0] raw_inc;
   logic [RAW_W-1:0] shifted;
   logic [7:0]       scaled_now;
   logic [7:0]       shadow_r;
   logic [7:0]       shadow_g;
   logic [7:0]       red_q;
   logic [7:0]       green_q;
   logic [7:0]       blue_q;
   logic [1:0]       filt;
   logic             edge_pulse;
   logic             phase_done;

   sync_edge_detect u_sync (
      .clock    (clock),
      .reset_n  (reset_n),
      .async_in (bus.sensor_out),
      .rise     (edge_pulse)
   );

   assign phase_done = (cnt == '0);

   always_comb begin
      next_state = state;
      unique case (state)
         ST_IDLE:     if (bus.start)  next_state = ST_SETTLE_R;
         ST_SETTLE_R: if (phase_done) next_state = ST_GATE_R;
         ST_GATE_R:   if (phase_done) next_state = ST_SETTLE_G;
         ST_SETTLE_G: if (phase_done) next_state = ST_GATE_G;
         ST_GATE_G:   if (phase_done) next_state = ST_SETTLE_B;
         ST_SETTLE_B: if (phase_done) next_state = ST_GATE_B;
         ST_GATE_B:   if (phase_done) next_state = ST_DONE;
         ST_DONE:                     next_state = ST_IDLE;
         default:                     next_state = ST_IDLE;
      endcase
   end

   // The count including this cycle's edge, so the last gate cycle is never lost.
   always_comb begin
      raw_inc = raw;
      if (edge_pulse && (raw != '1)) begin
         raw_inc = raw + 1'b1;
      end
      shifted    = raw_inc >> SHIFT;
      scaled_now = shifted[7:0];
      if ((shifted >> 8) != '0) begin
         scaled_now = 8'hFF;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         raw      <= '0;
         filt     <= FILT_RED;
         shadow_r <= '0;
         shadow_g <= '0;
         red_q    <= '0;
         green_q  <= '0;
         blue_q   <= '0;
      end else begin
         state <= next_state;

         if (next_state != state) begin
            if (is_gate(next_state)) begin
               cnt <= CNT_W'(GATE_CYCLES - 1);
            end else begin
               cnt <= CNT_W'(SETTLE_CYCLES - 1);
            end
         end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
         end

         if (is_settle(next_state) && (next_state != state)) begin
            filt <= filter_for(next_state);
         end

         if (is_gate(next_state) && !is_gate(state)) begin
            raw <= '0;
         end else if (is_gate(state)) begin
            raw <= raw_inc;
         end

         // Blue goes straight to the output so all three update on the DONE edge.
         if (phase_done) begin
            case (state)
               ST_GATE_R: shadow_r <= scaled_now;
               ST_GATE_G: shadow_g <= scaled_now;
               ST_GATE_B: begin
                  red_q   <= shadow_r;
                  green_q <= shadow_g;
                  blue_q  <= scaled_now;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.s2    = filt[1];
   assign bus.s3    = filt[0];
   assign bus.red   = red_q;
   assign bus.green = green_q;
   assign bus.blue  = blue_q;
   assign bus.valid = (state == ST_DONE);
   assign bus.busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_color_sampler.sv
// Directed bench for color_sampler: four instances cover the default, SHIFT=2,
// and two saturation configurations, each fed by a filter-aware sensor model.
module tb_color_sampler;
   import color_sensor_pkg::*;

   typedef struct {
      string name;
      int    mode;
      int    exp_r;
      int    exp_g;
      int    exp_b;
      int    exp_r2;
      int    exp_g2;
      int    exp_b2;
   } vec_t;

   logic clock = 1'b0;
   logic reset_n;
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   int   base   = 0;
   int   mode   = 0;
   vec_t vecs[4];

   color_sampler_if bus0();
   color_sampler_if bus1();
   color_sampler_if bus2();
   color_sampler_if bus3();

   color_sampler #(.GATE_CYCLES(100), .SETTLE_CYCLES(4), .RAW_W(16), .SHIFT(0)) dut0 (
      .clock(clock), .reset_n(reset_n), .bus(bus0));
   color_sampler #(.GATE_CYCLES(100), .SETTLE_CYCLES(4), .RAW_W(16), .SHIFT(2)) dut1 (
      .clock(clock), .reset_n(reset_n), .bus(bus1));
   color_sampler #(.GATE_CYCLES(1000), .SETTLE_CYCLES(4), .RAW_W(16), .SHIFT(0)) dut2 (
      .clock(clock), .reset_n(reset_n), .bus(bus2));
   color_sampler #(.GATE_CYCLES(1000), .SETTLE_CYCLES(4), .RAW_W(8), .SHIFT(0)) dut3 (
      .clock(clock), .reset_n(reset_n), .bus(bus3));

   always #5 clock = ~clock;

   initial begin
      forever begin
         @(posedge clock);
         cyc++;
      end
   end

   // Mode 0: period by filter (red 20, green 10, blue 4); 1: one pulse per settle window only;
   // 2: fixed period 4; 3: fixed period 50.
   function automatic logic sensor_model(input int m, input logic [1:0] f, input int c, input int rel);
      int p;
      p = 2;
      case (m)
         0: p = (f == 2'b00) ? 20 : (f == 2'b11) ? 10 : (f == 2'b01) ? 4 : 2;
         1: return (rel == 1) || (rel == 105) || (rel == 209);
         2: p = 4;
         3: p = 50;
         default: p = 2;
      endcase
      return (c % p) < (p / 2);
   endfunction

   initial begin
      bus0.sensor_out = 1'b0;
      bus1.sensor_out = 1'b0;
      bus2.sensor_out = 1'b0;
      bus3.sensor_out = 1'b0;
      forever begin
         @(negedge clock);
         #1;
         bus0.sensor_out = sensor_model(mode, {bus0.s2, bus0.s3}, cyc, cyc - base);
         bus1.sensor_out = sensor_model(mode, {bus1.s2, bus1.s3}, cyc, cyc - base);
         bus2.sensor_out = cyc[0];
         bus3.sensor_out = cyc[0];
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Pulses start on dut0/dut1, then runs until dut0 raises valid or the limit expires.
   task automatic applyStimulus(input int m, input int limit, output int vcyc,
                                output int busy_gap, output int filts);
      logic [5:0] f;
      mode = m;
      f    = '0;
      @(negedge clock);
      bus0.start = 1'b1;
      bus1.start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      base       = cyc - 1;
      bus0.start = 1'b0;
      bus1.start = 1'b0;
      vcyc       = -1;
      busy_gap   = 0;
      for (int i = 0; i < limit; i++) begin
         int rel;
         rel = cyc - base;
         if (!bus0.busy) busy_gap++;
         if (rel == 1)   f[5:4] = {bus0.s2, bus0.s3};
         if (rel == 105) f[3:2] = {bus0.s2, bus0.s3};
         if (rel == 209) f[1:0] = {bus0.s2, bus0.s3};
         if (bus0.valid) begin
            vcyc = rel;
            break;
         end
         @(negedge clock);
      end
      filts = int'(f);
   endtask

   task automatic checkIdleCleared(input string tag);
      checkOutput({tag, " red"},   int'(bus0.red),   0);
      checkOutput({tag, " green"}, int'(bus0.green), 0);
      checkOutput({tag, " blue"},  int'(bus0.blue),  0);
      checkOutput({tag, " valid"}, int'(bus0.valid), 0);
      checkOutput({tag, " busy"},  int'(bus0.busy),  0);
      checkOutput({tag, " s2s3"},  int'({bus0.s2, bus0.s3}), 0);
   endtask

   initial begin
      int vcyc, gap, filts, vcount, first_v, prev_v, found;

      vecs[0] = '{name: "filter_periods", mode: 0, exp_r: 5,  exp_g: 10, exp_b: 25, exp_r2: 1, exp_g2: 2, exp_b2: 6};
      vecs[1] = '{name: "settle_only",    mode: 1, exp_r: 0,  exp_g: 0,  exp_b: 0,  exp_r2: 0, exp_g2: 0, exp_b2: 0};
      vecs[2] = '{name: "period4",        mode: 2, exp_r: 25, exp_g: 25, exp_b: 25, exp_r2: 6, exp_g2: 6, exp_b2: 6};
      vecs[3] = '{name: "period50",       mode: 3, exp_r: 2,  exp_g: 2,  exp_b: 2,  exp_r2: 0, exp_g2: 0, exp_b2: 0};

      reset_n    = 1'b0;
      bus0.start = 1'b0;
      bus1.start = 1'b0;
      bus2.start = 1'b0;
      bus3.start = 1'b0;
      repeat (3) @(negedge clock);
      checkIdleCleared("por");
      reset_n = 1'b1;

      for (int v = 0; v < 4; v++) begin
         applyStimulus(vecs[v].mode, 400, vcyc, gap, filts);
         checkOutput({vecs[v].name, " valid_cycle"}, vcyc, 313);
         checkOutput({vecs[v].name, " busy_gap"}, gap, 0);
         checkOutput({vecs[v].name, " red"},   int'(bus0.red),   vecs[v].exp_r);
         checkOutput({vecs[v].name, " green"}, int'(bus0.green), vecs[v].exp_g);
         checkOutput({vecs[v].name, " blue"},  int'(bus0.blue),  vecs[v].exp_b);
         checkOutput({vecs[v].name, " shift2 valid"}, int'(bus1.valid), 1);
         checkOutput({vecs[v].name, " shift2 red"},   int'(bus1.red),   vecs[v].exp_r2);
         checkOutput({vecs[v].name, " shift2 green"}, int'(bus1.green), vecs[v].exp_g2);
         checkOutput({vecs[v].name, " shift2 blue"},  int'(bus1.blue),  vecs[v].exp_b2);
         if (v == 0) checkOutput("filter_sequence", filts, 6'b00_11_01);
         @(negedge clock);
         checkOutput({vecs[v].name, " valid_after"}, int'(bus0.valid), 0);
         checkOutput({vecs[v].name, " busy_after"},  int'(bus0.busy),  0);
      end

      // Reset held for three cycles in the middle of the green gate window.
      mode = 0;
      @(negedge clock);
      bus0.start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      base       = cyc - 1;
      bus0.start = 1'b0;
      while ((cyc - base) < 150) @(negedge clock);
      checkOutput("mid_gate busy", int'(bus0.busy), 1);
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      checkIdleCleared("mid_reset");
      reset_n = 1'b1;
      applyStimulus(0, 400, vcyc, gap, filts);
      checkOutput("post_reset valid_cycle", vcyc, 313);
      checkOutput("post_reset red",   int'(bus0.red),   5);
      checkOutput("post_reset green", int'(bus0.green), 10);
      checkOutput("post_reset blue",  int'(bus0.blue),  25);

      // Extra start pulses while busy must not queue a second measurement.
      @(negedge clock);
      bus0.start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      base       = cyc - 1;
      bus0.start = 1'b0;
      vcount     = 0;
      for (int i = 0; i < 700; i++) begin
         int rel;
         rel = cyc - base;
         bus0.start = (rel == 50) || (rel == 200);
         if (bus0.valid) vcount++;
         @(negedge clock);
      end
      bus0.start = 1'b0;
      checkOutput("busy_start valid_count", vcount, 1);

      // Continuous operation with start tied high.
      @(negedge clock);
      bus0.start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      base    = cyc - 1;
      vcount  = 0;
      first_v = -1;
      prev_v  = -1;
      for (int i = 0; i < 1000; i++) begin
         int rel;
         rel = cyc - base;
         if (bus0.valid) begin
            vcount++;
            if (first_v < 0) first_v = rel;
            else checkOutput("continuous period", rel - prev_v, 314);
            prev_v = rel;
         end
         @(negedge clock);
      end
      bus0.start = 1'b0;
      checkOutput("continuous first_valid", first_v, 313);
      checkOutput("continuous valid_count", vcount, 3);
      found = 0;
      for (int i = 0; i < 400; i++) begin
         if (!bus0.busy) begin
            found = 1;
            break;
         end
         @(negedge clock);
      end
      checkOutput("continuous drain_idle", found, 1);

      // Saturation: period-2 sensor over a 1000-cycle gate gives 500 raw edges.
      @(negedge clock);
      bus2.start = 1'b1;
      bus3.start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      base       = cyc - 1;
      bus2.start = 1'b0;
      bus3.start = 1'b0;
      vcyc       = -1;
      for (int i = 0; i < 3100; i++) begin
         if (bus2.valid) begin
            vcyc = cyc - base;
            break;
         end
         @(negedge clock);
      end
      checkOutput("sat valid_cycle", vcyc, 3013);
      checkOutput("sat red",   int'(bus2.red),   255);
      checkOutput("sat green", int'(bus2.green), 255);
      checkOutput("sat blue",  int'(bus2.blue),  255);
      checkOutput("raw8 valid", int'(bus3.valid), 1);
      checkOutput("raw8 red",   int'(bus3.red),   255);
      checkOutput("raw8 green", int'(bus3.green), 255);
      checkOutput("raw8 blue",  int'(bus3.blue),  255);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
